// File: rtl/div_unit_rv_if.sv
// ---------------------------------------------------------------------------
// div_unit_rv_if
// Request/response bundle between the EXE-stage issue logic and the
// div_unit_rv iterative divider.
//
// Handshake: the requester raises req_in with op/operands/tag and keeps all
// of them stable until the divider accepts. An accept happens on a rising
// clock edge where req_in=1, kill_in=0 and busy_out=0. A request seen while
// busy_out=1 is dropped, not queued. ready_out is a one-cycle pulse; while it
// is high, result_out/tag_out hold the completed op. No back-pressure is
// applied to the response.
//
// Signals (master = requester, slave = divider)
//   req_in       m->s  request valid
//   op_in        m->s  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend_in  m->s  rs1
//   divisor_in   m->s  rs2
//   tag_in       m->s  tag returned with the result
//   kill_in      m->s  abort op in flight
//   busy_out     s->m  op in CALC or FIX
//   ready_out    s->m  result valid pulse
//   result_out   s->m  quotient or remainder
//   tag_out      s->m  tag of completed op
//   dbg_state    s->m  divider FSM state (00 IDLE, 01 CALC, 10 FIX, 11 DONE)
// ---------------------------------------------------------------------------
interface div_unit_rv_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             req_in;
    logic [1:0]       op_in;
    logic [XLEN-1:0]  dividend_in;
    logic [XLEN-1:0]  divisor_in;
    logic [TAG_W-1:0] tag_in;
    logic             kill_in;
    logic             busy_out;
    logic             ready_out;
    logic [XLEN-1:0]  result_out;
    logic [TAG_W-1:0] tag_out;
    logic [1:0]       dbg_state;

    modport master (
        output req_in, op_in, dividend_in, divisor_in, tag_in, kill_in,
        input  busy_out, ready_out, result_out, tag_out, dbg_state
    );

    modport slave (
        input  req_in, op_in, dividend_in, divisor_in, tag_in, kill_in,
        output busy_out, ready_out, result_out, tag_out, dbg_state
    );
endinterface

// File: rtl/div_unit_rv.sv
// ---------------------------------------------------------------------------
// div_unit_rv
// Iterative radix-2 restoring divider for the RISC-V M extension
// (DIV/DIVU/REM/REMU). One operation in flight, tagged result, kill support.
//
// Ports
//   clk_in    : clock, all state updates on the rising edge
//   reset_in  : asynchronous, active-high reset
//   bus       : div_unit_rv_if.slave (request, operands, tag, kill, and the
//               busy/ready/result/tag/dbg_state responses)
//
// Parameters
//   XLEN  : operand/result width (>= 8, even)
//   TAG_W : width of the tag carried with an op
//
// Optional feature macro: DIV_EARLY_OUT_EN
//   Defined   : on accept, if |dividend| < |divisor| the CALC phase is
//               skipped (quotient 0, remainder |dividend|), result after 2 cycles.
//   Undefined : every non-special op spends XLEN cycles in CALC.
//
// Timing (latency counted with the accept edge as cycle 1)
//   divide by zero / signed overflow : ready_out after 1 cycle
//   early out (macro defined)        : ready_out after 2 cycles
//   normal                           : ready_out after XLEN+2 cycles
// ---------------------------------------------------------------------------
module div_unit_rv #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic           clk_in,
    input  logic           reset_in,
    div_unit_rv_if.slave   bus
);

    localparam int CNT_W = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    // Partial remainder. The XLEN+1-bit intermediate only exists for one
    // cycle inside the step logic; after each restoring step PR < |b|, so
    // XLEN bits are enough to hold it between cycles.
    logic [XLEN-1:0]  r_pr;
    // Holds |a| at start; dividend bits shift out of the top while quotient
    // bits shift in at the bottom, so after XLEN steps it is the quotient.
    logic [XLEN-1:0]  r_quot;
    logic [XLEN-1:0]  r_div;
    logic             r_is_rem;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [TAG_W-1:0] r_tag;
    logic             r_ready;
    logic [XLEN-1:0]  r_result;
    logic [TAG_W-1:0] r_tag_out;

    // -----------------------------------------------------------------------
    // Accept-side decode
    // -----------------------------------------------------------------------
    logic            w_signed;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_mag_a;
    logic [XLEN-1:0] w_mag_b;
    logic            w_idle_or_done;
    logic            w_accept;
    logic            w_div_zero;
    logic            w_overflow;
    logic [XLEN-1:0] w_special_res;
    logic            w_early;

    assign w_signed = ~bus.op_in[0];
    assign w_a_neg  = w_signed & bus.dividend_in[XLEN-1];
    assign w_b_neg  = w_signed & bus.divisor_in[XLEN-1];

    // Negating MIN wraps back to MIN, which read as unsigned is exactly
    // 2^(XLEN-1): the correct magnitude, so no extra bit is needed.
    assign w_mag_a = w_a_neg ? -bus.dividend_in : bus.dividend_in;
    assign w_mag_b = w_b_neg ? -bus.divisor_in  : bus.divisor_in;

    assign w_idle_or_done = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_accept       = bus.req_in & ~bus.kill_in & w_idle_or_done;

    assign w_div_zero = (bus.divisor_in == '0);
    assign w_overflow = w_signed && (bus.dividend_in == MIN_VAL) && (bus.divisor_in == '1);

    // RISC-V defined results: x/0 -> all ones, x%0 -> x;
    // MIN/-1 -> MIN, MIN%-1 -> 0.
    always_comb begin
        w_special_res = '0;
        if (w_div_zero) begin
            w_special_res = bus.op_in[1] ? bus.dividend_in : '1;
        end else begin
            w_special_res = bus.op_in[1] ? '0 : MIN_VAL;
        end
    end

`ifdef DIV_EARLY_OUT_EN
    assign w_early = (w_mag_a < w_mag_b);
`else
    assign w_early = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // One restoring step: shift the next dividend bit into PR and try to
    // subtract |b|. The trial difference fits XLEN+1 signed bits because
    // PR < |b| < 2^XLEN, so its top bit is a reliable borrow flag.
    // -----------------------------------------------------------------------
    logic [XLEN:0]   w_shift;
    logic [XLEN:0]   w_diff;
    logic            w_ge;
    logic [XLEN-1:0] w_pr_next;

    assign w_shift   = {r_pr, r_quot[XLEN-1]};
    assign w_diff    = w_shift - {1'b0, r_div};
    assign w_ge      = ~w_diff[XLEN];
    assign w_pr_next = w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];

    // -----------------------------------------------------------------------
    // Sign fix-up applied in FIX
    // -----------------------------------------------------------------------
    logic [XLEN-1:0] w_quot_fix;
    logic [XLEN-1:0] w_rem_fix;
    logic [XLEN-1:0] w_fix_res;

    assign w_quot_fix = r_neg_q ? -r_quot : r_quot;
    assign w_rem_fix  = r_neg_r ? -r_pr   : r_pr;
    assign w_fix_res  = r_is_rem ? w_rem_fix : w_quot_fix;

    // -----------------------------------------------------------------------
    // FSM and datapath
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_pr      <= '0;
            r_quot    <= '0;
            r_div     <= '0;
            r_is_rem  <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_tag     <= '0;
            r_ready   <= 1'b0;
            r_result  <= '0;
            r_tag_out <= '0;
        end else begin
            // ready_out is high only for the cycle right after entering DONE.
            r_ready <= 1'b0;

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        r_tag    <= bus.tag_in;
                        r_is_rem <= bus.op_in[1];
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                        r_div    <= w_mag_b;
                        r_cnt    <= CNT_W'(XLEN);
                        if (w_div_zero || w_overflow) begin
                            r_result  <= w_special_res;
                            r_tag_out <= bus.tag_in;
                            r_ready   <= 1'b1;
                            r_state   <= S_DONE;
                        end else if (w_early) begin
                            r_quot  <= '0;
                            r_pr    <= w_mag_a;
                            r_state <= S_FIX;
                        end else begin
                            r_quot  <= w_mag_a;
                            r_pr    <= '0;
                            r_state <= S_CALC;
                        end
                    end else begin
                        // Covers kill in DONE and kill arriving with a request.
                        r_state <= S_IDLE;
                    end
                end

                S_CALC: begin
                    if (bus.kill_in) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_pr   <= w_pr_next;
                        r_quot <= {r_quot[XLEN-2:0], w_ge};
                        r_cnt  <= r_cnt - CNT_W'(1);
                        if (r_cnt == CNT_W'(1)) begin
                            r_state <= S_FIX;
                        end
                    end
                end

                S_FIX: begin
                    if (bus.kill_in) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_result  <= w_fix_res;
                        r_tag_out <= r_tag;
                        r_ready   <= 1'b1;
                        r_state   <= S_DONE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.busy_out   = (r_state == S_CALC) || (r_state == S_FIX);
    assign bus.ready_out  = r_ready;
    assign bus.result_out = r_result;
    assign bus.tag_out    = r_tag_out;
    assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_div_unit_rv.sv
module tb_div_unit_rv;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;
  localparam logic [XLEN-1:0] MIN_VAL = 32'h8000_0000;
  localparam int MAX_WAIT = 100;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  div_unit_rv_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

  div_unit_rv #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk_in   (clk),
    .reset_in (rst),
    .bus      (bus)
  );

  // ---------------------------------------------------------------- scoreboard
  logic [XLEN-1:0]  exp_q[$];
  logic [TAG_W-1:0] tag_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%08h expected 0x%08h", name, obs, exp);
    end
  endtask

  // Reference model: RISC-V M-extension division semantics.
  function automatic logic [XLEN-1:0] ref_result(input logic [1:0] op, input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
    logic ovf;
    ovf = (a == MIN_VAL) && (b == '1);
    case (op)
      2'b00: ref_result = (b == 0) ? '1 : (ovf ? MIN_VAL : XLEN'($signed(a) / $signed(b)));
      2'b01: ref_result = (b == 0) ? '1 : a / b;
      2'b10: ref_result = (b == 0) ? a  : (ovf ? '0 : XLEN'($signed(a) % $signed(b)));
      default: ref_result = (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_latency(input logic [1:0] op, input logic [XLEN-1:0] a,
                                     input logic [XLEN-1:0] b);
    logic sgn;
    logic [XLEN-1:0] ma, mb;
    sgn = ~op[0];
    ma = (sgn && a[XLEN-1]) ? -a : a;
    mb = (sgn && b[XLEN-1]) ? -b : b;
    if (b == 0) return 1;
    if (sgn && a == MIN_VAL && b == '1) return 1;
`ifdef DIV_EARLY_OUT_EN
    if (ma < mb) return 2;
`endif
    return XLEN + 2;
  endfunction

  // ---------------------------------------------------------------- drivers
  task automatic drive_req(input logic [1:0] op, input logic [XLEN-1:0] a,
                           input logic [XLEN-1:0] b, input logic [TAG_W-1:0] tag);
    bus.req_in      = 1'b1;
    bus.op_in       = op;
    bus.dividend_in = a;
    bus.divisor_in  = b;
    bus.tag_in      = tag;
  endtask

  // Waits (after an edge, sampling #1 later) for ready_out; lat counts edges.
  task automatic wait_ready(inout int lat);
    while (!bus.ready_out && lat < MAX_WAIT) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic pop_compare(input string name);
    logic [XLEN-1:0] e;
    logic [TAG_W-1:0] t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check({name, " result"}, bus.result_out, e);
    check({name, " tag"}, XLEN'(bus.tag_out), XLEN'(t));
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input logic [TAG_W-1:0] tag);
    int lat;
    @(negedge clk);
    drive_req(op, a, b, tag);
    exp_q.push_back(ref_result(op, a, b));
    tag_q.push_back(tag);
    @(posedge clk); #1;
    bus.req_in = 1'b0;
    lat = 1;
    wait_ready(lat);
    check({name, " latency"}, XLEN'(lat), XLEN'(exp_latency(op, a, b)));
    pop_compare(name);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int lat;
    int t1;
    int seen;

    bus.req_in = 1'b0;
    bus.op_in = 2'b00;
    bus.dividend_in = '0;
    bus.divisor_in = '0;
    bus.tag_in = '0;
    bus.kill_in = 1'b0;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", XLEN'(bus.busy_out), 0);
    check("reset ready", XLEN'(bus.ready_out), 0);
    check("reset result", bus.result_out, 0);
    check("reset tag", XLEN'(bus.tag_out), 0);
    check("reset state", XLEN'(bus.dbg_state), 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed values
    run_op("divu 100/7", 2'b01, 32'd100, 32'd7, 5'd3);
    run_op("remu 100/7", 2'b11, 32'd100, 32'd7, 5'd3);
    run_op("div -7/2",   2'b00, 32'hFFFF_FFF9, 32'd2, 5'd4);
    run_op("rem -7/2",   2'b10, 32'hFFFF_FFF9, 32'd2, 5'd5);
    run_op("rem 7/-2",   2'b10, 32'd7, 32'hFFFF_FFFE, 5'd6);
    run_op("div min/-1", 2'b00, MIN_VAL, 32'hFFFF_FFFF, 5'd7);
    run_op("rem min/-1", 2'b10, MIN_VAL, 32'hFFFF_FFFF, 5'd8);
    run_op("divu x/0",   2'b01, 32'h1234_5678, 32'd0, 5'd9);
    run_op("remu 5/0",   2'b11, 32'd5, 32'd0, 5'd10);
    run_op("div -5/0",   2'b00, 32'hFFFF_FFFB, 32'd0, 5'd11);
    run_op("rem -5/0",   2'b10, 32'hFFFF_FFFB, 32'd0, 5'd12);
    run_op("divu 3/10",  2'b01, 32'd3, 32'd10, 5'd13);
    run_op("rem -3/10",  2'b10, 32'hFFFF_FFFD, 32'd10, 5'd14);
    run_op("divu max/1", 2'b01, 32'hFFFF_FFFF, 32'd1, 5'd15);
    run_op("div min/2",  2'b00, MIN_VAL, 32'd2, 5'd16);

    // Random operands, divisor width varied so quotients span the range
    for (int i = 0; i < 6; i++) begin
      run_op("random", 2'($urandom_range(0, 3)), $urandom(),
             $urandom() >> $urandom_range(0, 31), 5'($urandom_range(0, 31)));
    end

    // Kill in CALC cycle 10: no ready, busy drops next cycle
    @(negedge clk);
    drive_req(2'b01, 32'd1000, 32'd3, 5'd20);
    @(posedge clk); #1;
    bus.req_in = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.kill_in = 1'b1;
    @(posedge clk); #1;
    bus.kill_in = 1'b0;
    check("kill busy", XLEN'(bus.busy_out), 0);
    check("kill ready", XLEN'(bus.ready_out), 0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.ready_out) seen = 1;
    end
    check("kill no ready later", XLEN'(seen), 0);
    run_op("after kill", 2'b00, 32'hFFFF_FF9C, 32'd7, 5'd21);

    // Kill asserted in the same cycle as a request: not accepted
    @(negedge clk);
    drive_req(2'b01, 32'd50, 32'd5, 5'd22);
    bus.kill_in = 1'b1;
    @(posedge clk); #1;
    bus.req_in = 1'b0;
    bus.kill_in = 1'b0;
    check("req+kill busy", XLEN'(bus.busy_out), 0);
    check("req+kill state", XLEN'(bus.dbg_state), 0);

    // Back-to-back: second request held high, accepted in first op's DONE
    @(negedge clk);
    drive_req(2'b01, 32'd100, 32'd7, 5'd1);
    exp_q.push_back(ref_result(2'b01, 32'd100, 32'd7));
    tag_q.push_back(5'd1);
    @(posedge clk); #1;
    drive_req(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd2);
    exp_q.push_back(ref_result(2'b10, 32'hFFFF_FFF9, 32'd2));
    tag_q.push_back(5'd2);
    lat = 1;
    wait_ready(lat);
    t1 = cyc;
    check("b2b first latency", XLEN'(lat), XLEN'(XLEN + 2));
    pop_compare("b2b first");
    @(posedge clk); #1;
    bus.req_in = 1'b0;
    check("b2b single pulse", XLEN'(bus.ready_out), 0);
    check("b2b second accepted", XLEN'(bus.busy_out), 1);
    lat = 2;
    wait_ready(lat);
    check("b2b spacing", XLEN'(cyc - t1), XLEN'(XLEN + 2));
    pop_compare("b2b second");

    // Async reset in the middle of CALC
    @(negedge clk);
    drive_req(2'b01, 32'd50000, 32'd3, 5'd9);
    @(posedge clk); #1;
    bus.req_in = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midreset busy", XLEN'(bus.busy_out), 0);
    check("midreset ready", XLEN'(bus.ready_out), 0);
    check("midreset result", bus.result_out, 0);
    check("midreset tag", XLEN'(bus.tag_out), 0);
    check("midreset state", XLEN'(bus.dbg_state), 0);
    @(negedge clk);
    rst = 1'b0;
    run_op("after reset", 2'b11, 32'd1000, 32'd7, 5'd30);

    check("queue empty", XLEN'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
